// File: rtl/sqrt_rr_arbiter_if.sv
// ============================================================================
// Module      : sqrt_rr_arbiter_if
// Description : Requester, core and response bundle for sqrt_rr_arbiter.
//               The slave modport is the arbiter's view. The master modport is
//               the view of the client engines and the sqrt core together.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sqrt_rr_arbiter_if #(
  parameter int NREQ     = 4,
  parameter int WII      = 9,
  parameter int WIF      = 10,
  parameter int WOI      = 9,
  parameter int WOF      = 10,
  parameter int SQRT_LAT = 10
);
  // Requester side
  logic                            issue_en;
  logic [NREQ-1:0]                 req_valid;
  logic [NREQ*(WII+WIF)-1:0]       req_data;
  logic [NREQ-1:0]                 req_ready;

  // Core side
  logic [WII+WIF-1:0]              core_in;
  logic [WOI+WOF-1:0]              core_out;
  logic                            core_upflow;
  logic                            core_downflow;

  // Response side and status
  logic [NREQ-1:0]                 rsp_valid;
  logic [WOI+WOF-1:0]              rsp_data;
  logic                            rsp_upflow;
  logic                            rsp_downflow;
  logic [$clog2(SQRT_LAT+2)-1:0]   inflight;
  logic                            idle;

  modport slave (
    input  issue_en, req_valid, req_data, core_out, core_upflow, core_downflow,
    output req_ready, core_in, rsp_valid, rsp_data, rsp_upflow, rsp_downflow,
           inflight, idle
  );

  modport master (
    output issue_en, req_valid, req_data, core_out, core_upflow, core_downflow,
    input  req_ready, core_in, rsp_valid, rsp_data, rsp_upflow, rsp_downflow,
           inflight, idle
  );
endinterface

`default_nettype wire

// File: rtl/sqrt_rr_arbiter.sv
// ============================================================================
// Module      : sqrt_rr_arbiter
// Description : Round-robin front end that shares one pipelined fixed-point
//               sqrt core between NREQ requesters. It accepts at most one
//               operand per cycle. The requester ID travels down a tag line
//               that matches the core latency, and each result comes back as
//               a one-hot strobe to the requester that issued it.
// Options     : SQRT_ARB_FLAGS_EN - when defined, the core overflow and
//               underflow flags are registered alongside each result.
//               Otherwise both response flags are tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sqrt_rr_arbiter #(
  parameter int NREQ     = 4,   // must match the interface instance
  parameter int WII      = 9,
  parameter int WIF      = 10,
  parameter int WOI      = 9,
  parameter int WOF      = 10,
  parameter int SQRT_LAT = 10   // pipeline depth of the attached core
) (
  input  logic             clk,
  input  logic             rst,
  sqrt_rr_arbiter_if.slave bus
);

  localparam int c_IW    = WII + WIF;
  localparam int c_IDW   = $clog2(NREQ);
  localparam int c_CW    = $clog2(SQRT_LAT + 2);
  localparam int c_DEPTH = SQRT_LAT + 1;

  // The extra bit lets the search index pass NREQ-1 before it wraps.
  localparam logic [c_IDW:0]   c_NREQ_X  = (c_IDW + 1)'(NREQ);
  localparam logic [c_IDW-1:0] c_LAST_ID = c_IDW'(NREQ - 1);

  // Arbitration
  logic [c_IDW-1:0]  r_ptr;
  logic              w_found;
  logic [c_IDW-1:0]  w_gnt_id;
  logic [c_IDW:0]    w_idx;
  logic [c_IDW-1:0]  w_cand;
  logic [NREQ-1:0]   w_grant;
  logic [c_IW-1:0]   w_operand;

  // Issue and tag line
  logic [c_IW-1:0]               r_core_in;
  logic [c_DEPTH-1:0]            r_tag_vld;
  logic [c_DEPTH-1:0][c_IDW-1:0] r_tag_id;
  logic                          w_ret;
  logic [c_IDW-1:0]              w_ret_id;
  logic [NREQ-1:0]               w_ret_onehot;

  // Response and bookkeeping
  logic [NREQ-1:0]          r_rsp_valid;
  logic [WOI+WOF-1:0]       r_rsp_data;
  logic [c_CW-1:0]          r_inflight;

  // Scan cyclically from ptr and grant the first valid requester.
  always_comb begin
    w_found  = 1'b0;
    w_gnt_id = '0;
    w_idx    = '0;
    w_cand   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = {1'b0, r_ptr} + (c_IDW + 1)'(k);
      if (w_idx >= c_NREQ_X) begin
        w_idx = w_idx - c_NREQ_X;
      end
      w_cand = w_idx[c_IDW-1:0];
      if (!w_found && bus.issue_en && bus.req_valid[w_cand]) begin
        w_found  = 1'b1;
        w_gnt_id = w_cand;
      end
    end
  end

  // Expand the winner into the one-hot ready vector.
  always_comb begin
    w_grant = '0;
    if (w_found) begin
      w_grant[w_gnt_id] = 1'b1;
    end
  end

  assign bus.req_ready = w_grant;
  assign w_operand     = bus.req_data[w_gnt_id*c_IW +: c_IW];

  // Move the pointer past the winner. The explicit wrap covers NREQ values
  // that are not a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= (w_gnt_id == c_LAST_ID) ? '0 : w_gnt_id + 1'b1;
    end
  end

  // Register the granted operand into the core. Zero marks an idle slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_core_in <= '0;
    end else begin
      r_core_in <= w_found ? w_operand : '0;
    end
  end

  assign bus.core_in = r_core_in;

  // The tag line shifts every cycle, in step with the non-stalling core.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag_vld <= '0;
      r_tag_id  <= '0;
    end else begin
      r_tag_vld <= {r_tag_vld[c_DEPTH-2:0], w_found};
      r_tag_id  <= {r_tag_id[c_DEPTH-2:0], w_gnt_id};
    end
  end

  assign w_ret    = r_tag_vld[c_DEPTH-1];
  assign w_ret_id = r_tag_id[c_DEPTH-1];

  // Decode the returning tag into its one-hot response strobe.
  always_comb begin
    w_ret_onehot = '0;
    w_ret_onehot[w_ret_id] = 1'b1;
  end

  // Capture the core result while the matching tag leaves the line.
  // Between results the data bus holds its last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else if (w_ret) begin
      r_rsp_valid <= w_ret_onehot;
      r_rsp_data  <= bus.core_out;
    end else begin
      r_rsp_valid <= '0;
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;

`ifdef SQRT_ARB_FLAGS_EN
  logic r_rsp_upflow;
  logic r_rsp_downflow;

  // Flags follow rsp_valid, so they are cleared in cycles with no result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_upflow   <= 1'b0;
      r_rsp_downflow <= 1'b0;
    end else if (w_ret) begin
      r_rsp_upflow   <= bus.core_upflow;
      r_rsp_downflow <= bus.core_downflow;
    end else begin
      r_rsp_upflow   <= 1'b0;
      r_rsp_downflow <= 1'b0;
    end
  end

  assign bus.rsp_upflow   = r_rsp_upflow;
  assign bus.rsp_downflow = r_rsp_downflow;
`else
  logic w_unused_flags;

  assign w_unused_flags   = bus.core_upflow | bus.core_downflow;
  assign bus.rsp_upflow   = 1'b0;
  assign bus.rsp_downflow = 1'b0;
`endif

  // Count accepted operands that have not yet produced a response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight <= '0;
    end else if (w_found && !w_ret) begin
      r_inflight <= r_inflight + c_CW'(1);
    end else if (!w_found && w_ret) begin
      r_inflight <= r_inflight - c_CW'(1);
    end
  end

  assign bus.inflight = r_inflight;
  assign bus.idle     = (r_inflight == '0) && (bus.req_valid == '0);

endmodule

`default_nettype wire

// File: tb/tb_sqrt_rr_arbiter.sv
// ============================================================================
// Module      : tb_sqrt_rr_arbiter
// Description : Directed bench for sqrt_rr_arbiter. A table-driven stand-in
//               for the sqrt core with the same latency is placed behind the
//               arbiter. A per-cycle expectation schedule checks every
//               response slot. Build with SQRT_ARB_FLAGS_EN to check the
//               flag path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sqrt_rr_arbiter;

  localparam int NREQ      = 4;
  localparam int WII       = 9;
  localparam int WIF       = 10;
  localparam int WOI       = 9;
  localparam int WOF       = 10;
  localparam int SQRT_LAT  = 10;
  localparam int c_IW      = WII + WIF;
  localparam int c_OW      = WOI + WOF;
  localparam int c_RSP_LAT = SQRT_LAT + 2;
  localparam int c_SLOTS   = 1024;

  // Operands (WIF=10) and their square roots
  localparam logic [c_IW-1:0] c_OP1  = 19'h00400;  // 1.0
  localparam logic [c_IW-1:0] c_OP4  = 19'h01000;  // 4.0
  localparam logic [c_IW-1:0] c_OP9  = 19'h02400;  // 9.0
  localparam logic [c_IW-1:0] c_OP16 = 19'h04000;  // 16.0
  localparam logic [c_OW-1:0] c_RT1  = 19'h00400;  // 1.0
  localparam logic [c_OW-1:0] c_RT2  = 19'h00800;  // 2.0
  localparam logic [c_OW-1:0] c_RT3  = 19'h00C00;  // 3.0
  localparam logic [c_OW-1:0] c_RT4  = 19'h01000;  // 4.0

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit mon_en  = 1'b0;
  bit sched_en = 1'b1;

  int              exp_id   [c_SLOTS];
  logic [c_OW-1:0] exp_data [c_SLOTS];
  logic            exp_up   [c_SLOTS];
  logic            exp_dn   [c_SLOTS];

  sqrt_rr_arbiter_if #(
    .NREQ(NREQ), .WII(WII), .WIF(WIF), .WOI(WOI), .WOF(WOF), .SQRT_LAT(SQRT_LAT)
  ) bus ();

  sqrt_rr_arbiter #(
    .NREQ(NREQ), .WII(WII), .WIF(WIF), .WOI(WOI), .WOF(WOF), .SQRT_LAT(SQRT_LAT)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [c_OW-1:0] root_of(input logic [c_IW-1:0] x);
    case (x)
      c_OP1:   return c_RT1;
      c_OP4:   return c_RT2;
      c_OP9:   return c_RT3;
      c_OP16:  return c_RT4;
      default: return 19'h7FFFF;
    endcase
  endfunction

  // Core stand-in: SQRT_LAT register stages, with the result and flags
  // computed from the operand leaving the last stage.
  logic [c_IW-1:0] core_pipe [SQRT_LAT];

  always @(posedge clk) begin
    core_pipe[0] <= bus.core_in;
    for (int k = 1; k < SQRT_LAT; k++) core_pipe[k] <= core_pipe[k-1];
  end

  assign bus.core_out      = root_of(core_pipe[SQRT_LAT-1]);
  assign bus.core_upflow   = (core_pipe[SQRT_LAT-1] == c_OP9);
  assign bus.core_downflow = (core_pipe[SQRT_LAT-1] == c_OP4);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Check every response slot against the schedule, including slots where
  // no response is expected.
  always @(negedge clk) begin
    if (mon_en) begin
      int e;
      e = exp_id[cyc];
      check("rsp_valid", 32'(bus.rsp_valid), (e >= 0) ? (32'd1 << e) : 32'd0);
      if (e >= 0) check("rsp_data", 32'(bus.rsp_data), 32'(exp_data[cyc]));
`ifdef SQRT_ARB_FLAGS_EN
      check("rsp_upflow", 32'(bus.rsp_upflow), 32'(exp_up[cyc]));
      check("rsp_downflow", 32'(bus.rsp_downflow), 32'(exp_dn[cyc]));
`else
      check("rsp_upflow_off", 32'(bus.rsp_upflow), 32'd0);
      check("rsp_downflow_off", 32'(bus.rsp_downflow), 32'd0);
`endif
    end
  end

  task automatic clear_schedule();
    for (int i = 0; i < c_SLOTS; i++) begin
      exp_id[i]   = -1;
      exp_data[i] = '0;
      exp_up[i]   = 1'b0;
      exp_dn[i]   = 1'b0;
    end
  endtask

  // Drive one cycle, check the grant, and schedule the expected response.
  task automatic step(input logic [NREQ-1:0] v, input logic en,
                      input logic [NREQ-1:0] exp_rdy, input string tag);
    logic [c_IW-1:0] op;
    @(negedge clk);
    bus.req_valid = v;
    bus.issue_en  = en;
    #1;
    check(tag, 32'(bus.req_ready), 32'(exp_rdy));
    if (sched_en) begin
      for (int i = 0; i < NREQ; i++) begin
        if (exp_rdy[i]) begin
          op = bus.req_data[i*c_IW +: c_IW];
          exp_id[cyc + c_RSP_LAT]   = i;
          exp_data[cyc + c_RSP_LAT] = root_of(op);
          exp_up[cyc + c_RSP_LAT]   = (op == c_OP9);
          exp_dn[cyc + c_RSP_LAT]   = (op == c_OP4);
        end
      end
    end
  endtask

  // Assert reset between clock edges and confirm that it clears state at once.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    bus.req_valid = '0;
    bus.issue_en  = 1'b0;
    clear_schedule();
    #1;
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_inflight", 32'(bus.inflight), 32'd0);
    check("rst_core_in", 32'(bus.core_in), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.issue_en = 1'b1;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.issue_en  = 1'b0;
    bus.req_data  = '0;
    clear_schedule();

    // Reset state
    repeat (2) @(negedge clk);
    bus.issue_en = 1'b1;
    #1;
    check("reset_req_ready", 32'(bus.req_ready), 32'd0);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rsp_data", 32'(bus.rsp_data), 32'd0);
    check("reset_core_in", 32'(bus.core_in), 32'd0);
    check("reset_inflight", 32'(bus.inflight), 32'd0);
    check("reset_idle", 32'(bus.idle), 32'd1);
    check("reset_upflow", 32'(bus.rsp_upflow), 32'd0);
    check("reset_downflow", 32'(bus.rsp_downflow), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Single request: requester 2 sends 4.0, expecting 2.0 after 12 cycles
    bus.req_data = {c_OP16, c_OP4, c_OP1, c_OP9};
    step(4'b0100, 1'b1, 4'b0100, "t1_grant");
    for (int i = 1; i <= 12; i++) begin
      step(4'b0000, 1'b1, 4'b0000, "t1_nogrant");
      check("t1_inflight", 32'(bus.inflight), (i < 12) ? 32'd1 : 32'd0);
    end
    check("t1_idle", 32'(bus.idle), 32'd1);

    // Full contention: grants rotate 0,1,2,3 twice
    do_reset();
    bus.req_data = {c_OP16, c_OP9, c_OP4, c_OP1};
    for (int i = 0; i < 8; i++) step(4'b1111, 1'b1, 4'b0001 << (i % 4), "t2_grant");
    for (int i = 0; i < 14; i++) step(4'b0000, 1'b1, 4'b0000, "t2_drain");
    check("t2_inflight_end", 32'(bus.inflight), 32'd0);

    // Pointer fairness: 3 alone, then 1 and 3 alternate
    do_reset();
    step(4'b1000, 1'b1, 4'b1000, "t3_grant");
    step(4'b1000, 1'b1, 4'b1000, "t3_grant");
    for (int i = 0; i < 6; i++)
      step(4'b1010, 1'b1, (i % 2 == 0) ? 4'b0010 : 4'b1000, "t3_grant");
    for (int i = 0; i < 14; i++) step(4'b0000, 1'b1, 4'b0000, "t3_drain");
    check("t3_inflight_end", 32'(bus.inflight), 32'd0);

    // issue_en low with three results in flight
    do_reset();
    step(4'b0111, 1'b1, 4'b0001, "t4_grant");
    step(4'b0111, 1'b1, 4'b0010, "t4_grant");
    step(4'b0111, 1'b1, 4'b0100, "t4_grant");
    for (int i = 0; i < 14; i++) begin
      step(4'b0111, 1'b0, 4'b0000, "t4_hold");
      check("t4_idle_busy", 32'(bus.idle), 32'd0);
    end
    check("t4_inflight_end", 32'(bus.inflight), 32'd0);
    step(4'b0000, 1'b1, 4'b0000, "t4_release");
    check("t4_idle_end", 32'(bus.idle), 32'd1);

    // Reset with five operations in flight: all of them are discarded
    do_reset();
    sched_en = 1'b0;
    for (int i = 0; i < 5; i++) step(4'b1111, 1'b1, 4'b0001 << (i % 4), "t5_grant");
    step(4'b0000, 1'b1, 4'b0000, "t5_stop");
    check("t5_inflight_pre", 32'(bus.inflight), 32'd5);
    do_reset();
    sched_en = 1'b1;
    for (int i = 0; i < 20; i++) step(4'b0000, 1'b1, 4'b0000, "t5_quiet");
    check("t5_inflight_end", 32'(bus.inflight), 32'd0);

    // Flags: 9.0 carries overflow and 4.0 carries underflow
    do_reset();
    bus.req_data = {c_OP16, c_OP1, c_OP4, c_OP9};
    step(4'b0011, 1'b1, 4'b0001, "t6_grant");
    step(4'b0011, 1'b1, 4'b0010, "t6_grant");
    for (int i = 0; i < 14; i++) step(4'b0000, 1'b1, 4'b0000, "t6_drain");

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
